// File: rtl/bsg_wormhole_test_checker_if.sv
// rtl/bsg_wormhole_test_checker_if.sv - flit link handshake into the wormhole test checker
interface bsg_wormhole_test_checker_if #(
    parameter int width_p = 32
);
    logic               valid_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;

    modport master (output valid_i, output data_i, input ready_o);
    modport slave  (input valid_i, input data_i, output ready_o);
endinterface

// File: rtl/bsg_wormhole_test_checker.sv
// rtl/bsg_wormhole_test_checker.sv - sink/checker for wormhole demo traffic packets
module bsg_wormhole_test_checker #(
    parameter int width_p          = 32,
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int len_width_p      = 4,
    parameter int reserved_width_p = 0,
    parameter int header_on_lsb_p  = 0,
    parameter int counter_width_p  = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,
    input  logic                       enable_i,
    bsg_wormhole_test_checker_if.slave link_if,
    output logic [counter_width_p-1:0] packets_o,
    output logic [counter_width_p-1:0] errors_o,
    output logic                       error_o,
    output logic [len_width_p-1:0]     last_len_o
);

    // Header field positions: either stacked down from the MSB or up from bit 0.
    localparam int X_LO   = (header_on_lsb_p != 0) ? reserved_width_p
                                                   : width_p - reserved_width_p - x_cord_width_p;
    localparam int Y_LO   = (header_on_lsb_p != 0) ? X_LO + x_cord_width_p
                                                   : X_LO - y_cord_width_p;
    localparam int LEN_LO = (header_on_lsb_p != 0) ? Y_LO + y_cord_width_p
                                                   : Y_LO - len_width_p;

    localparam logic [0:0] ST_HEAD = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    localparam logic [counter_width_p-1:0] CNT_ONE = counter_width_p'(1);
    localparam logic [len_width_p-1:0]     LEN_ONE = len_width_p'(1);

    // Two-entry input buffer
    logic [width_p-1:0] r_fifo_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_fifo_cnt;

    logic               w_fifo_ready;
    logic               w_fifo_v;
    logic               w_enq;
    logic               w_deq;
    logic [width_p-1:0] w_flit;

    assign w_fifo_ready    = (r_fifo_cnt != 2'd2);
    assign w_fifo_v        = (r_fifo_cnt != 2'd0);
    assign w_enq           = link_if.valid_i & w_fifo_ready;
    assign w_deq           = w_fifo_v & enable_i;
    assign w_flit          = r_fifo_mem[r_rd_ptr];
    assign link_if.ready_o = w_fifo_ready;

    // Buffer storage; contents are meaningless while the occupancy count says empty.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_fifo_mem[r_wr_ptr] <= link_if.data_i;
        end
    end

    // Buffer pointers and occupancy; reset discards whatever was queued.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_enq) r_wr_ptr <= ~r_wr_ptr;
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            case ({w_enq, w_deq})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Header fields of the flit at the buffer head
    logic [x_cord_width_p-1:0] w_x;
    logic [y_cord_width_p-1:0] w_y;
    logic [len_width_p-1:0]    w_len;

    assign w_x   = w_flit[X_LO   +: x_cord_width_p];
    assign w_y   = w_flit[Y_LO   +: y_cord_width_p];
    assign w_len = w_flit[LEN_LO +: len_width_p];

    logic [0:0]                 r_state;
    logic [len_width_p-1:0]     r_expected;
    logic [counter_width_p-1:0] r_packets;
    logic [counter_width_p-1:0] r_errors;
    logic                       r_error;
    logic [len_width_p-1:0]     r_last_len;

    logic [width_p-1:0] w_expected_ext;
    logic               w_dest_bad;
    logic               w_body_bad;
    logic               w_count_err;
    logic               w_count_pkt;

    assign w_expected_ext = width_p'(r_expected);
    assign w_dest_bad     = (w_x != my_x_i) || (w_y != my_y_i);
    assign w_body_bad     = (w_flit != w_expected_ext);

    // A header can both fail its destination check and complete a packet in one cycle.
    always_comb begin
        w_count_err = 1'b0;
        w_count_pkt = 1'b0;
        if (w_deq) begin
            if (r_state == ST_HEAD) begin
                w_count_err = w_dest_bad;
                w_count_pkt = (w_len == '0);
            end else begin
                w_count_err = w_body_bad;
                w_count_pkt = (r_expected == '0);
            end
        end
    end

    // Packet parser: header decode, count-down payload tracking and status counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= ST_HEAD;
            r_expected <= '0;
            r_packets  <= '0;
            r_errors   <= '0;
            r_error    <= 1'b0;
            r_last_len <= '0;
        end else begin
            if (w_count_pkt && (r_packets != '1)) r_packets <= r_packets + CNT_ONE;
            if (w_count_err && (r_errors  != '1)) r_errors  <= r_errors  + CNT_ONE;
            if (w_count_err) r_error <= 1'b1;

            if (w_deq) begin
                if (r_state == ST_HEAD) begin
                    r_last_len <= w_len;
                    if (w_len != '0) begin
                        r_expected <= w_len - LEN_ONE;
                        r_state    <= ST_BODY;
                    end
                end else begin
                    if (r_expected == '0) begin
                        r_state <= ST_HEAD;
                    end else begin
                        r_expected <= r_expected - LEN_ONE;
                    end
                end
            end
        end
    end

    assign packets_o  = r_packets;
    assign errors_o   = r_errors;
    assign error_o    = r_error;
    assign last_len_o = r_last_len;

endmodule
